// File: rtl/ans_table_ctrl_if.sv
// Host/loader handshake bundle for the ANS table sequencer.
// Both sides use a 4-phase valid/ready handshake. On the host side the
// controller raises host_rdy, the host raises host_vld with host_data, the
// controller drops host_rdy, and the host drops host_vld. On the loader side
// the controller raises ld_vld with ld_data while ld_rdy is high. The loader
// signals acceptance by dropping ld_rdy. The controller then drops ld_vld,
// and the loader raises ld_rdy again when it is idle.
`timescale 1ns/1ps
interface ans_table_ctrl_if #(
   parameter int CNT_WIDTH = 8
) ();
   logic [CNT_WIDTH-1:0] host_data;
   logic                 host_vld;
   logic                 host_rdy;
   logic [CNT_WIDTH-1:0] ld_data;
   logic                 ld_vld;
   logic                 ld_rdy;

   // Controller side
   modport master (
      input  host_data, host_vld, ld_rdy,
      output host_rdy, ld_data, ld_vld
   );

   // Host plus loader side
   modport slave (
      output host_data, host_vld, ld_rdy,
      input  host_rdy, ld_data, ld_vld
   );
endinterface

// File: rtl/ans_table_ctrl.sv
// ANS frequency-table sequencer.
// The host sends SYM_COUNT symbol counts, and this block forwards each one to
// the count loader. It then accumulates the cumulative start values, one
// symbol per cycle. It checks that the total equals 2**PREC, and it enables
// the coder only for a valid table.
`timescale 1ns/1ps
module ans_table_ctrl #(
   parameter int SYM_COUNT = 16,
   parameter int SYM_WIDTH = 4,
   parameter int CNT_WIDTH = 8,
   parameter int PREC      = 8,
   parameter int CW        = CNT_WIDTH + SYM_WIDTH
) (
   input  logic                           clk,
   input  logic                           rst_n,
   input  logic                           i_start,
   ans_table_ctrl_if.master               bus,
   input  logic [SYM_COUNT*CNT_WIDTH-1:0] i_counts_flat,
   output logic [SYM_COUNT*CW-1:0]        o_cum_flat,
   output logic                           o_busy,
   output logic                           o_table_ok,
   output logic                           o_table_err,
   output logic                           o_coder_en,
   output logic [2:0]                     o_dbg_state,
   output logic [1:0]                     o_dbg_phase
);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_LOAD  = 3'd1,
      S_SUM   = 3'd2,
      S_CHECK = 3'd3,
      S_RUN   = 3'd4,
      S_ERR   = 3'd5
   } state_t;

   typedef enum logic [1:0] {
      P_HOST_WAIT = 2'd0,
      P_LD_ACK    = 2'd1,
      P_LD_REL    = 2'd2
   } phase_t;

   localparam logic [SYM_WIDTH-1:0] LAST_SYM = SYM_WIDTH'(SYM_COUNT - 1);
   localparam logic [CW-1:0]        TARGET   = {{(CW-1){1'b0}}, 1'b1} << PREC;

   state_t                 r_state;
   phase_t                 r_phase;
   logic [SYM_WIDTH-1:0]   r_sym_idx;
   logic [CW-1:0]          r_acc;
   logic [CW-1:0]          r_cum [SYM_COUNT];
   logic [CNT_WIDTH-1:0]   r_ld_data;
   logic                   r_ld_vld;
   logic                   r_host_rdy;
   logic                   r_busy;
   logic                   r_table_ok;
   logic                   r_table_err;
   logic                   r_coder_en;
   logic [CNT_WIDTH-1:0]   w_count;
   logic [CW-1:0]          w_count_ext;

   // Select the loader count of the symbol currently being summed.
   always_comb begin
      w_count     = i_counts_flat[r_sym_idx*CNT_WIDTH +: CNT_WIDTH];
      w_count_ext = {{SYM_WIDTH{1'b0}}, w_count};
   end

   // Flatten the cumulative table onto the output bus.
   always_comb begin
      o_cum_flat = '0;
      for (int i = 0; i < SYM_COUNT; i++) begin
         o_cum_flat[i*CW +: CW] = r_cum[i];
      end
   end

   assign bus.host_rdy = r_host_rdy;
   assign bus.ld_data  = r_ld_data;
   assign bus.ld_vld   = r_ld_vld;
   assign o_busy       = r_busy;
   assign o_table_ok   = r_table_ok;
   assign o_table_err  = r_table_err;
   assign o_coder_en   = r_coder_en;
   assign o_dbg_state  = r_state;
   assign o_dbg_phase  = r_phase;

   // Sequencer: host-to-loader bridging, serial prefix sum, total check.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= S_IDLE;
         r_phase     <= P_HOST_WAIT;
         r_sym_idx   <= '0;
         r_acc       <= '0;
         r_ld_data   <= '0;
         r_ld_vld    <= 1'b0;
         r_host_rdy  <= 1'b0;
         r_busy      <= 1'b0;
         r_table_ok  <= 1'b0;
         r_table_err <= 1'b0;
         r_coder_en  <= 1'b0;
         for (int i = 0; i < SYM_COUNT; i++) begin
            r_cum[i] <= '0;
         end
      end else begin
         case (r_state)
            S_IDLE, S_RUN, S_ERR: begin
               if (i_start) begin
                  r_state     <= S_LOAD;
                  r_phase     <= P_HOST_WAIT;
                  r_sym_idx   <= '0;
                  r_host_rdy  <= 1'b1;
                  r_ld_vld    <= 1'b0;
                  r_busy      <= 1'b1;
                  r_table_ok  <= 1'b0;
                  r_table_err <= 1'b0;
                  r_coder_en  <= 1'b0;
               end
            end

            S_LOAD: begin
               case (r_phase)
                  P_HOST_WAIT: begin
                     if (bus.host_vld && r_host_rdy) begin
                        r_ld_data  <= bus.host_data;
                        r_host_rdy <= 1'b0;
                        r_ld_vld   <= 1'b1;
                        r_phase    <= P_LD_ACK;
                     end
                  end
                  P_LD_ACK: begin
                     // A low ld_rdy means the loader has taken the word.
                     if (!bus.ld_rdy) begin
                        r_ld_vld <= 1'b0;
                        r_phase  <= P_LD_REL;
                     end
                  end
                  P_LD_REL: begin
                     // Wait for both sides to return to idle so that a long
                     // host pulse cannot be counted as a second word.
                     if (bus.ld_rdy && !bus.host_vld) begin
                        r_phase <= P_HOST_WAIT;
                        if (r_sym_idx == LAST_SYM) begin
                           r_state   <= S_SUM;
                           r_acc     <= '0;
                           r_sym_idx <= '0;
                        end else begin
                           r_sym_idx  <= r_sym_idx + 1'b1;
                           r_host_rdy <= 1'b1;
                        end
                     end
                  end
                  default: r_phase <= P_HOST_WAIT;
               endcase
            end

            S_SUM: begin
               r_cum[r_sym_idx] <= r_acc;
               r_acc            <= r_acc + w_count_ext;
               if (r_sym_idx == LAST_SYM) begin
                  r_state   <= S_CHECK;
                  r_sym_idx <= '0;
               end else begin
                  r_sym_idx <= r_sym_idx + 1'b1;
               end
            end

            S_CHECK: begin
               r_busy <= 1'b0;
               if (r_acc == TARGET) begin
                  r_state    <= S_RUN;
                  r_table_ok <= 1'b1;
                  r_coder_en <= 1'b1;
               end else begin
                  r_state     <= S_ERR;
                  r_table_err <= 1'b1;
                  r_coder_en  <= 1'b0;
               end
            end

            default: r_state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: doc/ans_table_ctrl.md
Name: ans_table_ctrl

Overview:
- Sequencer that builds the ANS frequency table before coding starts.
- Bridges a host byte stream into the symbol-count loader using the loader's 4-phase in_vld/in_rdy handshake, and counts exactly SYM_COUNT transfers.
- Then computes cumulative start values serially and checks that the total equals 2**PREC.
- Enables the coder only when the table is valid. Sits between the chip I/O and the loader/coder pair.

Parameters:
SYM_COUNT, 16, number of symbols (power of two)
SYM_WIDTH, 4, log2(SYM_COUNT)
CNT_WIDTH, 8, width of one symbol count
PREC, 8, probability precision; required count total is 2**PREC; PREC <= CNT_WIDTH+SYM_WIDTH-1
CW, CNT_WIDTH+SYM_WIDTH, width of cumulative/accumulator values

Ports:
clk  in  1  clock
rst_n  in  1  reset
start  in  1  level; sampled in IDLE/RUN/ERR to begin a (re)load
host_data  in  CNT_WIDTH  count value from host
host_vld  in  1  host 4-phase valid
host_rdy  out  1  host 4-phase ready
ld_data  out  CNT_WIDTH  count to loader
ld_vld  out  1  loader valid
ld_rdy  in  1  loader ready
counts_flat  in  SYM_COUNT*CNT_WIDTH  loader count table; symbol i at [i*CNT_WIDTH +: CNT_WIDTH]
cum_flat  out  SYM_COUNT*CW  cumulative start per symbol; symbol i at [i*CW +: CW]
busy  out  1  high in LOAD/SUM/CHECK
table_ok  out  1  table valid
table_err  out  1  total != 2**PREC
coder_en  out  1  coder enable

Behaviour:
- Reset: rst_n is asynchronous, active-low; clock clk. All outputs 0; cum_flat all 0; state IDLE; sym_idx 0; accumulator 0.
- States: IDLE, LOAD, SUM, CHECK, RUN, ERR.
- IDLE/RUN/ERR with start=1 -> LOAD next cycle:
  - table_ok, table_err, coder_en cleared the same edge.
  - sym_idx=0, sub-phase HOST_WAIT, host_rdy=1.
  - start is ignored in LOAD/SUM/CHECK.
- LOAD sub-phases, per symbol:
  - HOST_WAIT: host_rdy=1. On host_vld&&host_rdy, latch host_data into ld_data, host_rdy<=0, ld_vld<=1 -> LD_ACK.
  - LD_ACK: hold ld_vld=1 and ld_data stable until ld_rdy seen 0 (loader accepted). Then ld_vld<=0 -> LD_REL.
  - LD_REL: wait ld_rdy=1 and host_vld=0.
    - If sym_idx==SYM_COUNT-1 -> SUM, accumulator 0, sym_idx 0.
    - Else sym_idx+1, back to HOST_WAIT (host_rdy<=1).
  - host_rdy never reasserts while host_vld is still high: one host pulse = exactly one loader write.
- SUM: one symbol per cycle, i = 0..SYM_COUNT-1.
  - cum[i] <= acc; acc <= acc + counts[i] (zero-extended to CW, no overflow possible at defaults).
  - Takes exactly SYM_COUNT cycles, then CHECK.
- CHECK (1 cycle):
  - acc == 2**PREC -> RUN: table_ok=1, coder_en=1.
  - Otherwise -> ERR: table_err=1, coder_en=0.
- RUN/ERR hold outputs indefinitely until start or reset.
- Zero counts are legal: the symbol gets cum equal to the next symbol's cum.
- Reset mid-LOAD: controller returns to IDLE and the loader resets on the same rst_n, so loader counter and sym_idx stay aligned.
- Loader symbol index wraps modulo SYM_COUNT, so a full reload restarts at symbol 0 without extra sync.
- cum_flat keeps old values during LOAD and is overwritten only in SUM.
- busy = 1 in LOAD, SUM, CHECK.

Test Plan:
- Reset, then start=1 with 16 host transfers of 8'd16 via real loader -> 16 loader writes; SYM_COUNT+1 cycles after last LD_REL, table_ok=1, coder_en=1, cum[i]=16*i, busy=0.
- All counts 8'd15 -> total 240, table_err=1, table_ok=0, coder_en=0, cum[15]=225.
- Counts {255,1,0x14} -> table_ok=1; cum = 0,255,256,256,...,256.
- Host holds host_vld high for 10 cycles on first word -> exactly one loader write; host_rdy stays 0 until host_vld drops; sym_idx increments once.
- Assert rst_n=0 after 5 symbols loaded -> all outputs 0 asynchronously, IDLE. A full reload of 16×8'd16 then yields table_ok=1.
- In RUN, pulse start -> coder_en and table_ok drop at the next edge, busy=1. start asserted during SUM has no effect.
